// File: rtl/pucch_pkg.sv
// Shared types and constants for the PUCCH cyclic-shift alpha sequencer.
package pucch_pkg;

    localparam int NSLOT_SYMB = 14;
    localparam int NRB_SC     = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_RDY = 3'd2,
        GET      = 3'd3,
        WAIT_VAL = 3'd4,
        OUT      = 3'd5,
        DONE     = 3'd6
    } pucch_state_t;

    typedef struct packed {
        logic [7:0] nslot;
        logic [9:0] nid;
        logic [3:0] m0;
        logic [3:0] mcs;
        logic [3:0] start_sym;
        logic [3:0] nrof_sym;
    } pucch_alpha_cfg_t;

    // A resource is rejected when it is empty or runs past the end of the slot.
    function automatic logic cfg_bad(input logic [3:0] start_sym,
                                     input logic [3:0] nrof_sym,
                                     input logic [4:0] slot_len);
        logic [4:0] sum;
        sum = {1'b0, start_sym} + {1'b0, nrof_sym};
        return (nrof_sym == 4'd0) || (sum > slot_len);
    endfunction

endpackage

// File: rtl/pucch_alpha_seq_ctrl.sv
// Sequences one PUCCH resource through the alpha generator and streams one alpha per symbol.
// Optional generator watchdog: define PUCCH_ALPHA_TIMEOUT_EN.
module pucch_alpha_seq_ctrl
    import pucch_pkg::*;
#(
    parameter int NSLOT_SYMB = pucch_pkg::NSLOT_SYMB
`ifdef PUCCH_ALPHA_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 65535
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [7:0] i_nslot,
    input  logic [9:0] i_nid,
    input  logic [3:0] i_m0,
    input  logic [3:0] i_mcs,
    input  logic [3:0] i_start_sym,
    input  logic [3:0] i_nrof_sym,
    input  logic       i_abort,
    output logic       o_gen_start,
    output logic       o_gen_get,
    output logic [7:0] o_gen_nslot,
    output logic [9:0] o_gen_nid,
    output logic [3:0] o_gen_m0,
    output logic [3:0] o_gen_mcs,
    input  logic       i_gen_can_get,
    input  logic [4:0] i_gen_alpha,
    input  logic       i_gen_valid,
    output logic       o_alpha_valid,
    input  logic       i_alpha_ready,
    output logic [3:0] o_alpha,
    output logic [3:0] o_sym_idx,
    output logic       o_last,
    output logic       o_cfg_err,
    output logic       o_busy
);

    localparam logic [4:0] SLOT_LEN = 5'(NSLOT_SYMB);

    pucch_state_t     state_r;
    pucch_state_t     state_nxt_s;
    pucch_alpha_cfg_t cfg_r;
    logic [3:0]       sym_r;
    logic [3:0]       alpha_r;
    logic [3:0]       sym_idx_r;
    logic             last_r;
    logic             alpha_valid_r;
    logic             gen_start_r;
    logic             gen_get_r;
    logic             req_ready_r;
    logic             busy_r;
    logic             cfg_err_r;

    logic             cfg_load_s;
    logic             cfg_err_s;
    logic             sym_inc_s;
    logic             load_out_s;
    logic             accept_s;
    logic             kill_s;
    logic             tmo_hit_s;
    logic [4:0]       end_sym_s;
    logic             last_hit_s;

    assign end_sym_s  = {1'b0, cfg_r.start_sym} + {1'b0, cfg_r.nrof_sym} - 5'd1;
    assign last_hit_s = ({1'b0, sym_r} == end_sym_s);

`ifdef PUCCH_ALPHA_TIMEOUT_EN
    logic [15:0] tmo_r;

    // Watchdog counts wait cycles and restarts whenever the state changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_r <= 16'd0;
        end else if (state_nxt_s != state_r) begin
            tmo_r <= 16'd0;
        end else if ((state_r == WAIT_RDY) || (state_r == WAIT_VAL)) begin
            tmo_r <= tmo_r + 16'd1;
        end else begin
            tmo_r <= 16'd0;
        end
    end

    assign tmo_hit_s = ((state_r == WAIT_RDY) || (state_r == WAIT_VAL)) &&
                       (tmo_r == 16'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and per-cycle control strobes; abort and watchdog override everything.
    always_comb begin
        state_nxt_s = state_r;
        cfg_load_s  = 1'b0;
        cfg_err_s   = 1'b0;
        sym_inc_s   = 1'b0;
        load_out_s  = 1'b0;
        accept_s    = 1'b0;
        kill_s      = 1'b0;
        if ((state_r != IDLE) && i_abort) begin
            state_nxt_s = IDLE;
            kill_s      = 1'b1;
        end else if (tmo_hit_s) begin
            state_nxt_s = IDLE;
            kill_s      = 1'b1;
            cfg_err_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_valid) begin
                        cfg_load_s = 1'b1;
                        if (cfg_bad(i_start_sym, i_nrof_sym, SLOT_LEN)) begin
                            cfg_err_s = 1'b1;
                        end else begin
                            state_nxt_s = START;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                START: state_nxt_s = WAIT_RDY;
                WAIT_RDY: begin
                    if (i_gen_can_get) begin
                        state_nxt_s = GET;
                    end else begin
                        state_nxt_s = WAIT_RDY;
                    end
                end
                GET: state_nxt_s = WAIT_VAL;
                WAIT_VAL: begin
                    if (i_gen_valid) begin
                        if (sym_r < cfg_r.start_sym) begin
                            sym_inc_s   = 1'b1;
                            state_nxt_s = GET;
                        end else begin
                            load_out_s  = 1'b1;
                            state_nxt_s = OUT;
                        end
                    end else begin
                        state_nxt_s = WAIT_VAL;
                    end
                end
                OUT: begin
                    if (alpha_valid_r && i_alpha_ready) begin
                        accept_s = 1'b1;
                        if (last_r) begin
                            state_nxt_s = DONE;
                        end else begin
                            sym_inc_s   = 1'b1;
                            state_nxt_s = GET;
                        end
                    end else begin
                        state_nxt_s = OUT;
                    end
                end
                DONE: state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register plus control outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            gen_start_r <= 1'b0;
            gen_get_r   <= 1'b0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            gen_start_r <= (state_nxt_s == START);
            gen_get_r   <= (state_nxt_s == GET);
            req_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            cfg_err_r   <= cfg_err_s;
        end
    end

    // Configuration is captured only in IDLE, so it stays put for the whole resource.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_r <= '0;
        end else if (cfg_load_s) begin
            cfg_r <= '{nslot:     i_nslot,
                       nid:       i_nid,
                       m0:        i_m0,
                       mcs:       i_mcs,
                       start_sym: i_start_sym,
                       nrof_sym:  i_nrof_sym};
        end else begin
            cfg_r <= cfg_r;
        end
    end

    // Symbol counter tracks which slot symbol the next generator alpha belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_r <= 4'd0;
        end else if (state_r == START) begin
            sym_r <= 4'd0;
        end else if (sym_inc_s) begin
            sym_r <= sym_r + 4'd1;
        end else begin
            sym_r <= sym_r;
        end
    end

    // Output beat registers hold steady until the downstream accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alpha_r       <= 4'd0;
            sym_idx_r     <= 4'd0;
            last_r        <= 1'b0;
            alpha_valid_r <= 1'b0;
        end else begin
            if (load_out_s) begin
                alpha_r   <= i_gen_alpha[3:0];
                sym_idx_r <= sym_r;
                last_r    <= last_hit_s;
            end else begin
                alpha_r   <= alpha_r;
                sym_idx_r <= sym_idx_r;
                last_r    <= last_r;
            end
            if (kill_s) begin
                alpha_valid_r <= 1'b0;
            end else if (load_out_s) begin
                alpha_valid_r <= 1'b1;
            end else if (accept_s) begin
                alpha_valid_r <= 1'b0;
            end else begin
                alpha_valid_r <= alpha_valid_r;
            end
        end
    end

    assign o_req_ready   = req_ready_r;
    assign o_busy        = busy_r;
    assign o_cfg_err     = cfg_err_r;
    assign o_gen_start   = gen_start_r;
    assign o_gen_get     = gen_get_r;
    assign o_gen_nslot   = cfg_r.nslot;
    assign o_gen_nid     = cfg_r.nid;
    assign o_gen_m0      = cfg_r.m0;
    assign o_gen_mcs     = cfg_r.mcs;
    assign o_alpha_valid = alpha_valid_r;
    assign o_alpha       = alpha_r;
    assign o_sym_idx     = sym_idx_r;
    assign o_last        = last_r;

endmodule

// File: tb/tb_pucch_alpha_seq_ctrl.sv
// Directed bench for pucch_alpha_seq_ctrl with a behavioural generator and a stalling sink.
module tb_pucch_alpha_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [7:0] i_nslot;
    logic [9:0] i_nid;
    logic [3:0] i_m0;
    logic [3:0] i_mcs;
    logic [3:0] i_start_sym;
    logic [3:0] i_nrof_sym;
    logic       i_abort;
    logic       o_gen_start;
    logic       o_gen_get;
    logic [7:0] o_gen_nslot;
    logic [9:0] o_gen_nid;
    logic [3:0] o_gen_m0;
    logic [3:0] o_gen_mcs;
    logic       i_gen_can_get;
    logic [4:0] i_gen_alpha;
    logic       i_gen_valid;
    logic       o_alpha_valid;
    logic       i_alpha_ready;
    logic [3:0] o_alpha;
    logic [3:0] o_sym_idx;
    logic       o_last;
    logic       o_cfg_err;
    logic       o_busy;

    pucch_alpha_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_nslot       (i_nslot),
        .i_nid         (i_nid),
        .i_m0          (i_m0),
        .i_mcs         (i_mcs),
        .i_start_sym   (i_start_sym),
        .i_nrof_sym    (i_nrof_sym),
        .i_abort       (i_abort),
        .o_gen_start   (o_gen_start),
        .o_gen_get     (o_gen_get),
        .o_gen_nslot   (o_gen_nslot),
        .o_gen_nid     (o_gen_nid),
        .o_gen_m0      (o_gen_m0),
        .o_gen_mcs     (o_gen_mcs),
        .i_gen_can_get (i_gen_can_get),
        .i_gen_alpha   (i_gen_alpha),
        .i_gen_valid   (i_gen_valid),
        .o_alpha_valid (o_alpha_valid),
        .i_alpha_ready (i_alpha_ready),
        .o_alpha       (o_alpha),
        .o_sym_idx     (o_sym_idx),
        .o_last        (o_last),
        .o_cfg_err     (o_cfg_err),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int c_ns, c_nid, c_m0, c_mcs;
    int start_cnt, gen_k, pend, get_viol, stall_viol, cfg_viol, stall_left;
    int lat_fix, stall_max;
    bit lat_rand, cfg_watch, holding;
    logic [25:0] snap;
    logic [4:0]  pend_alpha;
    logic [8:0]  held;
    int q_alpha[$];
    int q_sym[$];
    int q_last[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference generator: ncs is an arbitrary deterministic function of slot, id and symbol.
    function automatic int model_alpha(input int k);
        int ncs;
        ncs = (c_ns * 7 + c_nid + k * 5) % 12;
        return (c_m0 + c_mcs + ncs) % 12;
    endfunction

    // Generator and sink models, evaluated 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        i_gen_valid = 1'b0;
        if (o_gen_start) begin
            start_cnt++;
            gen_k     = 0;
            pend      = 0;
            cfg_watch = 1'b1;
            snap      = {o_gen_nslot, o_gen_nid, o_gen_m0, o_gen_mcs};
        end else if (cfg_watch) begin
            if (snap != {o_gen_nslot, o_gen_nid, o_gen_m0, o_gen_mcs}) cfg_viol++;
            if (!o_busy) cfg_watch = 1'b0;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                i_gen_valid = 1'b1;
                i_gen_alpha = pend_alpha;
            end
        end
        if (o_gen_get) begin
            if (o_alpha_valid || (pend != 0)) get_viol++;
            pend_alpha = 5'(model_alpha(gen_k));
            gen_k++;
            pend = lat_rand ? int'($urandom_range(4, 1)) : lat_fix;
        end
        if (o_alpha_valid) begin
            if (holding) begin
                if (held != {o_alpha, o_sym_idx, o_last}) stall_viol++;
            end else begin
                held       = {o_alpha, o_sym_idx, o_last};
                holding    = 1'b1;
                stall_left = int'($urandom_range(stall_max, 0));
            end
            if (stall_left == 0) begin
                i_alpha_ready = 1'b1;
                q_alpha.push_back(int'(o_alpha));
                q_sym.push_back(int'(o_sym_idx));
                q_last.push_back(int'(o_last));
                holding = 1'b0;
            end else begin
                i_alpha_ready = 1'b0;
                stall_left--;
            end
        end else begin
            i_alpha_ready = 1'b0;
            holding       = 1'b0;
        end
    end

    task automatic issue_req(input int ns, input int nid, input int m0, input int mcs,
                             input int st, input int nr, input logic ab);
        int n;
        c_ns = ns; c_nid = nid; c_m0 = m0; c_mcs = mcs;
        q_alpha.delete(); q_sym.delete(); q_last.delete();
        start_cnt = 0; gen_k = 0; get_viol = 0; stall_viol = 0; cfg_viol = 0;
        n = 0;
        while (!o_req_ready && n < 100) begin
            @(posedge clk); #2; n++;
        end
        chk("req_ready_wait", int'(o_req_ready), 1);
        i_nslot = 8'(ns); i_nid = 10'(nid); i_m0 = 4'(m0); i_mcs = 4'(mcs);
        i_start_sym = 4'(st); i_nrof_sym = 4'(nr);
        i_req_valid = 1'b1;
        i_abort     = ab;
        @(posedge clk); #2;
        i_req_valid = 1'b0;
        i_abort     = 1'b0;
    endtask

    task automatic finish_req(input int st, input int nr);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(posedge clk); #2; n++;
        end
        chk("busy_timeout", int'(o_busy), 0);
        chk("req_ready_after", int'(o_req_ready), 1);
        chk("start_pulses", start_cnt, 1);
        chk("get_count", gen_k, st + nr);
        chk("out_count", q_sym.size(), nr);
        for (int i = 0; i < nr && i < q_sym.size(); i++) begin
            chk("sym_idx", q_sym[i], st + i);
            chk("alpha", q_alpha[i], model_alpha(st + i));
            chk("last", q_last[i], (i == nr - 1) ? 1 : 0);
        end
        chk("get_overlap", get_viol, 0);
        chk("stall_stable", stall_viol, 0);
        chk("cfg_stable", cfg_viol, 0);
        chk("gen_nslot", int'(o_gen_nslot), c_ns);
        chk("gen_nid", int'(o_gen_nid), c_nid);
        chk("gen_m0", int'(o_gen_m0), c_m0);
        chk("gen_mcs", int'(o_gen_mcs), c_mcs);
    endtask

    task automatic reject_req(input int st, input int nr);
        issue_req(5, 77, 1, 1, st, nr, 1'b0);
        chk("rej_err_pulse", int'(o_cfg_err), 1);
        chk("rej_busy", int'(o_busy), 0);
        chk("rej_ready", int'(o_req_ready), 1);
        @(posedge clk); #2;
        chk("rej_err_clear", int'(o_cfg_err), 0);
        chk("rej_no_start", start_cnt, 0);
    endtask

    initial begin
        int n;
        rst = 1'b0; i_req_valid = 1'b0; i_abort = 1'b0; i_gen_can_get = 1'b1;
        i_gen_alpha = 5'd0; i_gen_valid = 1'b0; i_alpha_ready = 1'b0;
        i_nslot = 8'd0; i_nid = 10'd0; i_m0 = 4'd0; i_mcs = 4'd0;
        i_start_sym = 4'd0; i_nrof_sym = 4'd0;
        lat_fix = 1; lat_rand = 1'b0; stall_max = 0;
        cfg_watch = 1'b0; holding = 1'b0; pend = 0; stall_left = 0;

        #3;
        chk("rst_ready", int'(o_req_ready), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ctrl", int'({o_alpha_valid, o_gen_start, o_gen_get, o_cfg_err, o_last}), 0);
        chk("rst_data", int'({o_alpha, o_sym_idx, o_gen_m0, o_gen_mcs}), 0);
        #19 rst = 1'b1;
        #1;
        chk("ready_before_edge", int'(o_req_ready), 0);
        @(posedge clk); #2;
        chk("ready_after_edge", int'(o_req_ready), 1);

        // Full slot, generator always ready, no stalls.
        issue_req(3, 17, 2, 0, 0, 14, 1'b0);
        chk("start_pulse", int'(o_gen_start), 1);
        chk("no_err_ok", int'(o_cfg_err), 0);
        finish_req(0, 14);

        // Tail of slot with random latency and back-pressure.
        lat_rand = 1'b1; stall_max = 5;
        issue_req(100, 1023, 11, 11, 10, 4, 1'b0);
        finish_req(10, 4);
        issue_req(159, 512, 6, 9, 3, 5, 1'b0);
        finish_req(3, 5);
        issue_req(7, 1, 0, 3, 13, 1, 1'b0);
        finish_req(13, 1);

        reject_req(12, 3);
        reject_req(5, 0);
        reject_req(0, 15);

        // Generator not ready: no get may be issued.
        lat_rand = 1'b0; lat_fix = 2; stall_max = 0;
        i_gen_can_get = 1'b0;
        issue_req(40, 511, 0, 7, 2, 2, 1'b0);
        repeat (10) begin
            @(posedge clk); #2;
        end
        chk("no_get_wo_can", gen_k, 0);
        chk("wait_busy", int'(o_busy), 1);
        i_gen_can_get = 1'b1;
        finish_req(2, 2);

        // Abort in WAIT_VAL after five discarded alphas.
        lat_fix = 4;
        issue_req(9, 200, 3, 5, 6, 4, 1'b0);
        n = 0;
        while (gen_k < 5 && n < 200) begin
            @(posedge clk); #2; n++;
        end
        chk("abort_reach5", gen_k, 5);
        @(posedge clk); #2;
        i_abort = 1'b1;
        @(posedge clk); #2;
        i_abort = 1'b0;
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_valid", int'(o_alpha_valid), 0);
        chk("abort_get", int'(o_gen_get), 0);
        chk("abort_ready", int'(o_req_ready), 1);
        chk("abort_no_out", q_sym.size(), 0);
        chk("abort_no_err", int'(o_cfg_err), 0);
        // Abort raised in IDLE together with a request: the request must still run.
        lat_fix = 1;
        issue_req(9, 200, 3, 5, 1, 3, 1'b1);
        finish_req(1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
